boot_memory: RTL
================

Name: boot_memory

Overview:
- Word-addressed RAM that answers the CPU's memory port: the CPU drives address, write-enable and write data, and this block returns read data.
- Contains a boot loader that fills the RAM from a streamed valid/ready word interface after reset.
- Holds the CPU in reset through its own reset output until loading completes.
- Sits between the top level and the cpu block; it is the responder end of the CPU memory interface.

Parameters:
ADDR_WIDTH, 6, address width; depth = 2**ADDR_WIDTH words
DATA_WIDTH, 16, word width
LOAD_BASE, 0, first address written by the loader

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
we  input  1  CPU write enable
addr  input  ADDR_WIDTH  CPU address
data  input  DATA_WIDTH  CPU write data
out  output  DATA_WIDTH  read data to CPU (registered)
ld_valid  input  1  loader word valid
ld_data  input  DATA_WIDTH  loader word
ld_last  input  1  marks final program word, qualified by ld_valid
ld_ready  output  1  loader can accept a word
cpu_rst_n  output  1  active-low reset to the cpu block
done  output  1  load finished, CPU running
error  output  1  load aborted (checksum mismatch, see Optional Feature)

Behaviour:
- Reset (async, rst_n=0):
  - state=LOAD, load pointer=LOAD_BASE.
  - out=0, ld_ready=0 during reset, cpu_rst_n=0, done=0, error=0.
  - RAM contents are not cleared.
- States:
  - LOAD
  - (CHECK only when the optional feature is compiled in)
  - RELEASE
  - RUN
  - ERROR
- LOAD:
  - ld_ready=1.
  - A word is accepted on a rising edge with ld_valid=1 and ld_ready=1: mem[ptr] <= ld_data, then ptr <= ptr+1.
  - If the accepted word has ld_last=1, or ptr = 2**ADDR_WIDTH-1: next state is RELEASE (CHECK if feature enabled). The pointer never wraps; the last address is written, then loading ends.
  - The CPU port (we, addr, data) is ignored; out holds 0.
- RELEASE:
  - ld_ready=0; exactly one cycle in this state, then RUN.
  - cpu_rst_n is registered and rises on the edge entering RUN, so the CPU sees its first active cycle one cycle after loader completion plus one.
- RUN:
  - cpu_rst_n=1, done=1, ld_ready=0; ld_valid is ignored.
  - Write: if we=1, mem[addr] <= data on the rising edge.
  - Read: out <= mem[addr] every rising edge, giving 1-cycle latency. The address presented in cycle N yields data in cycle N+1, which matches a fetch issued in one state and consumed in the next.
  - Simultaneous read and write to the same address: out returns the old (pre-write) contents. The new value is visible the following cycle.
  - The block stays in RUN until rst_n is asserted.
- ERROR:
  - error=1, cpu_rst_n=0, ld_ready=0.
  - The block stays in ERROR until reset.
- Reset mid-load or mid-run:
  - The block returns to LOAD with ptr=LOAD_BASE and cpu_rst_n=0 immediately (asynchronous).
  - Previously loaded words remain in RAM and are overwritten as reload proceeds.
- Width rules:
  - ptr is ADDR_WIDTH wide.
  - addr is used unmodified; no bounds check is needed because the full address space is implemented.

Optional Feature:
- Macro: BOOT_MEMORY_CHECKSUM_EN.
- When defined:
  - During LOAD a DATA_WIDTH running sum (mod 2**DATA_WIDTH) of accepted words is kept; it is cleared at reset.
  - After the last word, the block enters CHECK with ld_ready=1 and accepts exactly one more word, which is not written to RAM. ld_last is ignored for this word.
  - If the word equals the sum: next state RELEASE.
  - Otherwise: next state ERROR.
- When not defined:
  - No sum register and no CHECK state; LOAD goes directly to RELEASE.
  - error is tied to 0.

Test Plan:
- Load 3 words 0x1111, 0x2222, 0x3333 (last on third) from reset -> mem[0..2] written; ld_ready drops the cycle after the third accept; cpu_rst_n=1 and done=1 two edges after the third accept.
- Backpressure: ld_valid toggles 1,0,1 with words 0xA, 0xB -> only 2 writes (mem[0]=0xA, mem[1]=0xB); ptr does not advance on idle cycles.
- RUN: we=1, addr=5, data=0xBEEF on edge N, then addr=5 with we=0 -> out=0xBEEF after edge N+1.
- RUN read-during-write: mem[4]=0x0001; we=1, addr=4, data=0x00FF on one edge -> out=0x0001 that cycle, 0x00FF after the next read.
- Stream 64 words with no ld_last -> all addresses 0..63 written; loader stops at 63 and the 65th word is not accepted; cpu_rst_n rises.
- With BOOT_MEMORY_CHECKSUM_EN: load 0x0003, 0x0004 (last), checksum 0x0007 -> RUN. Repeat after reset with checksum 0x0008 -> error=1, cpu_rst_n stays 0. Assert rst_n mid-load -> cpu_rst_n=0 and ptr=0 immediately.

Source files
------------

// File: rtl/boot_memory.sv
// boot_memory: word RAM serving the CPU memory port, filled after reset by a
// streamed valid/ready loader; holds the CPU in reset until loading completes.
// Ports: clk, rst_n (async, active low); CPU port we/addr/data -> out
// (registered, 1-cycle latency); loader ld_valid/ld_data/ld_last -> ld_ready;
// status cpu_rst_n, done, error.
// Optional: define BOOT_MEMORY_CHECKSUM_EN to require a trailing checksum word.
module boot_memory #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 16,
    parameter int LOAD_BASE  = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data,
    output logic [DATA_WIDTH-1:0] out,
    input  logic                  ld_valid,
    input  logic [DATA_WIDTH-1:0] ld_data,
    input  logic                  ld_last,
    output logic                  ld_ready,
    output logic                  cpu_rst_n,
    output logic                  done,
    output logic                  error
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] PTR_BASE = ADDR_WIDTH'(LOAD_BASE);
    localparam logic [ADDR_WIDTH-1:0] PTR_MAX  = '1;

    typedef enum logic [2:0] {
        S_LOAD,
`ifdef BOOT_MEMORY_CHECKSUM_EN
        S_CHECK,
`endif
        S_RELEASE,
        S_RUN,
        S_ERROR
    } state_t;

    state_t                  state, next;
    logic [ADDR_WIDTH-1:0]   ptr;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [DATA_WIDTH-1:0]   out_q;
    logic                    ready_q, cpu_rst_q, done_q;
    logic                    ready_d, cpu_rst_d, done_d;
    logic                    accept, load_acc, load_end;
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_wa;
    logic [DATA_WIDTH-1:0]   mem_wd;

    assign accept   = ld_valid & ready_q;
    assign load_acc = accept & (state == S_LOAD);
    assign load_end = load_acc & (ld_last | (ptr == PTR_MAX));

`ifdef BOOT_MEMORY_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] sum;
    logic                  error_q, error_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sum <= '0;
        else if (load_acc)
            sum <= sum + ld_data;
    end
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_LOAD;
        else
            state <= next;
    end

    // Next-state logic
    always_comb begin
        next = state;
        case (state)
            S_LOAD: begin
`ifdef BOOT_MEMORY_CHECKSUM_EN
                if (load_end) next = S_CHECK;
`else
                if (load_end) next = S_RELEASE;
`endif
            end
`ifdef BOOT_MEMORY_CHECKSUM_EN
            S_CHECK: begin
                if (accept)
                    next = (ld_data == sum) ? S_RELEASE : S_ERROR;
            end
`endif
            S_RELEASE: next = S_RUN;
            S_RUN:     next = S_RUN;
            S_ERROR:   next = S_ERROR;
            default:   next = S_LOAD;
        endcase
    end

    // Output logic: decoded from the next state and registered, so every
    // status output changes on the same edge the state does.
    always_comb begin
        ready_d   = (next == S_LOAD);
`ifdef BOOT_MEMORY_CHECKSUM_EN
        ready_d   = ready_d | (next == S_CHECK);
        error_d   = (next == S_ERROR);
`endif
        cpu_rst_d = (next == S_RUN);
        done_d    = (next == S_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q   <= 1'b0;
            cpu_rst_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            ready_q   <= ready_d;
            cpu_rst_q <= cpu_rst_d;
            done_q    <= done_d;
        end
    end

`ifdef BOOT_MEMORY_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            error_q <= 1'b0;
        else
            error_q <= error_d;
    end
    assign error = error_q;
`else
    assign error = 1'b0;
`endif

    // Load pointer holds at the top address instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr <= PTR_BASE;
        else if (load_acc && ptr != PTR_MAX)
            ptr <= ptr + 1'b1;
    end

    // Single write port shared by loader and CPU.
    assign mem_we = load_acc | ((state == S_RUN) & we);
    assign mem_wa = (state == S_RUN) ? addr : ptr;
    assign mem_wd = (state == S_RUN) ? data : ld_data;

    // RAM contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we)
            mem[mem_wa] <= mem_wd;
    end

    // Registered read returns pre-write data on a same-address write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            out_q <= '0;
        else if (state == S_RUN)
            out_q <= mem[addr];
        else
            out_q <= '0;
    end

    assign out       = out_q;
    assign ld_ready  = ready_q;
    assign cpu_rst_n = cpu_rst_q;
    assign done      = done_q;

endmodule
